// File: rtl/twos_complement_pkg.sv
// -----------------------------------------------------------------------------
// twos_complement_pkg
// Shared types for the chunk-serial two's-complement unit: the operation mode
// encoding carried on in_mode and the control FSM state encoding.
// -----------------------------------------------------------------------------
package twos_complement_pkg;

    typedef enum logic [1:0] {
        PASS = 2'b00,
        NEG  = 2'b01,
        ABS  = 2'b10,
        ONES = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/twos_chunk_step.sv
// -----------------------------------------------------------------------------
// twos_chunk_step
// Combinational CHUNK-bit step: optionally inverts the operand chunk and adds
// the incoming carry.
//   a_i      : operand chunk
//   invert_i : 1 = use ~a_i
//   carry_i  : carry into this chunk
//   sum_o    : chunk result, truncated to CHUNK bits
//   carry_o  : carry out of this chunk
// -----------------------------------------------------------------------------
module twos_chunk_step #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic             invert_i,
    input  logic             carry_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             carry_o
);

    logic [CHUNK-1:0] opnd;

    assign opnd             = a_i ^ {CHUNK{invert_i}};
    assign {carry_o, sum_o} = {1'b0, opnd} + {{CHUNK{1'b0}}, carry_i};

endmodule

// File: rtl/twos_complement_seq.sv
// -----------------------------------------------------------------------------
// twos_complement_seq
// Chunk-serial pass / negate / abs / ones-complement of a WIDTH-bit operand,
// CHUNK bits per cycle, LSB chunk first. Result appears WIDTH/CHUNK cycles
// after acceptance and is held until the consumer takes it.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake (ready only in IDLE)
//   in_data, in_mode    : operand and mode (00 pass, 01 neg, 10 abs, 11 ones)
//   out_valid/out_ready : result handshake
//   out_data, out_ovf   : result and "not representable" flag
// Build option: define TWOS_COMPLEMENT_SEQ_SAT_EN to saturate overflowing
// results to the most-positive value instead of leaving them wrapped.
// -----------------------------------------------------------------------------
module twos_complement_seq
    import twos_complement_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS = ~MIN_NEG;

    state_e             state_q;
    logic [WIDTH-1:0]   op_q;        // operand, shifted right one chunk per step
    logic [WIDTH-1:0]   res_q;       // result, filled from the top one chunk per step
    logic [WIDTH-1:0]   res_d;
    logic [WIDTH-1:0]   out_data_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic               invert_q;
    logic               ovf_q;
    logic               out_valid_q;

    logic [CHUNK-1:0]   step_sum;
    logic               step_carry;

    // Acceptance-time decode of the mode into invert / carry-in / overflow.
    logic               acc_invert;
    logic               acc_carry;
    logic               acc_ovf;

    always_comb begin
        acc_invert = 1'b0;
        acc_carry  = 1'b0;
        unique case (mode_e'(in_mode))
            NEG: begin
                acc_invert = 1'b1;
                acc_carry  = 1'b1;
            end
            ABS: begin
                acc_invert = in_data[WIDTH-1];
                acc_carry  = in_data[WIDTH-1];
            end
            ONES:    acc_invert = 1'b1;
            default: ;
        endcase
    end

    assign acc_ovf = ((mode_e'(in_mode) == NEG) || (mode_e'(in_mode) == ABS)) &&
                     (in_data == MIN_NEG);

    twos_chunk_step #(
        .CHUNK (CHUNK)
    ) u_step (
        .a_i      (op_q[CHUNK-1:0]),
        .invert_i (invert_q),
        .carry_i  (carry_q),
        .sum_o    (step_sum),
        .carry_o  (step_carry)
    );

    // Shift form keeps WIDTH == CHUNK legal (no empty part-selects).
    assign res_d = (res_q >> CHUNK) | (WIDTH'(step_sum) << (WIDTH - CHUNK));

    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; a blocking = would let later lines see new values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            res_q       <= '0;
            out_data_q  <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            invert_q    <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= in_data;
                        invert_q <= acc_invert;
                        carry_q  <= acc_carry;
                        ovf_q    <= acc_ovf;
                        idx_q    <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    op_q    <= op_q >> CHUNK;
                    res_q   <= res_d;
                    carry_q <= step_carry;   // final carry-out is dropped on exit
                    idx_q   <= idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NCHUNK - 1)) begin
`ifdef TWOS_COMPLEMENT_SEQ_SAT_EN
                        out_data_q <= ovf_q ? MAX_POS : res_d;
`else
                        out_data_q <= res_d;
`endif
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = ovf_q & out_valid_q;

endmodule
